// File: rtl/alu_seq_ctrl.sv
// Hardwired control sequencer for a single-bus CPU datapath: fetch, decode,
// and execute of 3-operand, unary and MUL/DIV instructions as T-state strobes.
module alu_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 16,
    parameter int OPC_W   = 5,
    parameter int ZERO_R0 = 1,
    localparam int RW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] ir,
    output logic [NREG-1:0]   Rout,
    output logic [NREG-1:0]   Rin,
    output logic              PCout,
    output logic              IncPC,
    output logic              MARin,
    output logic              PCin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              LOin,
    output logic              HIin,
    output logic [OPC_W-1:0]  alu_op,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam int RA_HI  = DATA_W - OPC_W - 1;
    localparam int RB_HI  = RA_HI - RW;
    localparam int RC_HI  = RB_HI - RW;
    localparam int LOW_W  = RC_HI - RW + 1;

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    state_t           state, state_nxt;
    logic             t1_first;
    logic [OPC_W-1:0] op_q;
    logic [RW-1:0]    ra_q, rb_q, rc_q;

    logic [OPC_W-1:0] ir_op;
    logic [RW-1:0]    ir_ra, ir_rb, ir_rc;

    assign ir_op = ir[DATA_W-1 -: OPC_W];
    assign ir_ra = ir[RA_HI -: RW];
    assign ir_rb = ir[RB_HI -: RW];
    assign ir_rc = ir[RC_HI -: RW];

    // Bits below the Rc field carry no control information.
    generate
        if (LOW_W > 0) begin : g_low
            logic unused_ir_low;
            assign unused_ir_low = ^ir[LOW_W-1:0];
        end
    endgenerate

    function automatic logic is_3op(input logic [OPC_W-1:0] op);
        return (op >= OPC_W'(3)) && (op <= OPC_W'(11));
    endfunction

    function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
        return (op == OPC_W'(15)) || (op == OPC_W'(16));
    endfunction

    function automatic logic is_unary(input logic [OPC_W-1:0] op);
        return (op == OPC_W'(17)) || (op == OPC_W'(18));
    endfunction

    function automatic logic [NREG-1:0] dec(input logic [RW-1:0] r);
        return NREG'(1) << r;
    endfunction

    logic [NREG-1:0] ra_wr;
    assign ra_wr = (ZERO_R0 != 0 && ra_q == '0) ? '0 : dec(ra_q);

    // State register; t1_first marks the first T1 cycle so PC update is not repeated on stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            t1_first <= 1'b0;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state    <= state_nxt;
            t1_first <= (state == T0);
            if (state == T2) begin
                op_q <= ir_op;
                ra_q <= ir_ra;
                rb_q <= ir_rb;
                rc_q <= ir_rc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   if (mem_ready) state_nxt = T2;
            T2:   state_nxt = (is_3op(ir_op) || is_muldiv(ir_op) || is_unary(ir_op)) ? T3 : IDLE;
            T3:   state_nxt = T4;
            T4:   state_nxt = is_unary(op_q) ? IDLE : T5;
            T5:   state_nxt = is_muldiv(op_q) ? T6 : IDLE;
            T6:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Rout = '0;  Rin = '0;
        PCout = 1'b0;  IncPC = 1'b0;  MARin = 1'b0;  PCin = 1'b0;
        Read = 1'b0;  MDRin = 1'b0;  MDRout = 1'b0;  IRin = 1'b0;
        Yin = 1'b0;  Zin = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0;
        LOin = 1'b0;  HIin = 1'b0;
        alu_op = '0;  done = 1'b0;  illegal = 1'b0;
        busy = (state != IDLE);
        case (state)
            T0: begin
                PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zin = 1'b1;
            end
            T1: begin
                Read = 1'b1;  MDRin = 1'b1;
                Zlowout = t1_first;  PCin = t1_first;
            end
            T2: begin
                MDRout = 1'b1;  IRin = 1'b1;
                illegal = !(is_3op(ir_op) || is_muldiv(ir_op) || is_unary(ir_op));
            end
            T3: begin
                if (is_unary(op_q)) begin
                    Rout = dec(rb_q);  Zin = 1'b1;  alu_op = op_q;
                end else if (is_muldiv(op_q)) begin
                    Rout = dec(ra_q);  Yin = 1'b1;
                end else begin
                    Rout = dec(rb_q);  Yin = 1'b1;
                end
            end
            T4: begin
                if (is_unary(op_q)) begin
                    Zlowout = 1'b1;  Rin = ra_wr;  done = 1'b1;
                end else begin
                    Rout = is_muldiv(op_q) ? dec(rb_q) : dec(rc_q);
                    Zin = 1'b1;  alu_op = op_q;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv(op_q)) LOin = 1'b1;
                else begin
                    Rin = ra_wr;  done = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;  HIin = 1'b1;  done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: instruction/IR width.
REQ-002 The block SHALL have parameter NREG, default 16: general register count; RW = clog2(NREG).
REQ-003 The block SHALL have parameter OPC_W, default 5: opcode field width.
REQ-004 The block SHALL have parameter ZERO_R0, default 1: when 1, writes to R0 are suppressed.
REQ-005 The block SHALL have these ports:
 - clk  in  1  single clock; all state changes on rising edge.
 - reset  in  1  asynchronous, active-high reset.
 - start  in  1  request to execute one instruction; sampled in IDLE only.
 - mem_ready  in  1  fetch read complete.
 - ir  in  DATA_W  instruction word from IR register.
 - Rout / Rin  out  NREG  one-hot register bus-drive / load enables.
 - PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath strobes.
 - alu_op  out  OPC_W  operation select; valid only while Zin=1, else 0.
 - busy  out  1  high in every state except IDLE.
 - done  out  1  one-cycle pulse in the final state of a legal instruction.
 - illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-006 Fields SHALL be opcode=ir[DATA_W-1 -: OPC_W], Ra=next RW bits, Rb=next RW bits, Rc=next RW bits; fields SHALL be latched at end of T2.
REQ-007 Supported opcodes SHALL be: 3-op class ADD=3, SUB=4, AND=5, OR=6, ROR=7, ROL=8, SHR=9, SHRA=10, SHL=11; MULDIV class MUL=15, DIV=16; unary class NEG=17, NOT=18; all others illegal.
REQ-008 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6; state register only, outputs decoded from state plus latched fields.
REQ-009 IDLE: all strobes 0; start=1 -> T0 next edge.
REQ-010 T0: PCout, MARin, IncPC, Zin=1 -> T1.
REQ-011 T1: Zlowout, PCin, Read, MDRin=1; stays in T1 while mem_ready=0 (Zlowout/PCin asserted only on the first T1 cycle); mem_ready=1 -> T2.
REQ-012 T2: MDRout, IRin=1 -> T3, or -> IDLE with illegal=1 if opcode (from ir) unsupported.
REQ-013 3-op: T3 Rout[Rb], Yin; T4 Rout[Rc], Zin, alu_op=opcode; T5 Zlowout, Rin[Ra], done -> IDLE.
REQ-014 Unary: T3 Rout[Rb], Zin, alu_op=opcode; T4 Zlowout, Rin[Ra], done -> IDLE.
REQ-015 MULDIV: T3 Rout[Ra], Yin; T4 Rout[Rb], Zin, alu_op=opcode; T5 Zlowout, LOin; T6 Zhighout, HIin, done -> IDLE.
REQ-016 Rout and Rin SHALL each be one-hot or zero; at most one bus driver (any *out) active per cycle.
REQ-017 If ZERO_R0=1 and Ra=0, Rin SHALL be all zero in the write state; done still pulses.
REQ-018 start while busy SHALL be ignored; next instruction accepted earliest one cycle after done (IDLE).
REQ-019 Latency from accepted start to done, with mem_ready=1 in first T1 cycle: 6 cycles 3-op, 5 unary, 7 MULDIV; each extra T1 stall adds 1.

Reset
REQ-020 reset=1 SHALL immediately force IDLE, all outputs 0, latched fields 0, independent of clk.
REQ-021 reset asserted mid-instruction SHALL abandon it with no done; first start after release begins at T0.

Verification
REQ-022 ROR: ir=0x3A1B8000, start, mem_ready=1 -> T3 Rout=0x0008 Yin; T4 Rout=0x0080 Zin alu_op=7; T5 Rin=0x0010 Zlowout done; 6 cycles.
REQ-023 MUL: ir=0x79180000 (op15, Ra=2, Rb=3) -> T3 Rout=0x0004, T4 Rout=0x0008 alu_op=15, T5 LOin, T6 HIin done; 7 cycles.
REQ-024 Stall: mem_ready low 3 cycles in T1 -> Read/MDRin held, PCin only first cycle, done 3 cycles later than REQ-022.
REQ-025 Illegal: ir opcode 31 -> illegal pulse in T2, no Yin/Zin/Rin, busy low next cycle.
REQ-026 R0 dest: ADD with Ra=0, ZERO_R0=1 -> Rin=0 in T5, done=1; reset in T4 of ROR -> outputs 0 at once, no done.
